// File: rtl/md_unit.sv
// Multiply/divide unit for the execute stage: owns HI/LO and runs mult/div
// as a fixed-latency operation behind a registered busy flag.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   hi_n_q, hi_n_d, lo_n_q, lo_n_d;

  logic [63:0] prod_s, prod_u;
  logic        sdiv;
  logic [31:0] dvd, dvs, uq, ur, quo, rem;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case.
  assign sdiv = (md_op == OP_DIV);
  assign dvd  = (sdiv && a[31]) ? (32'd0 - a) : a;
  assign dvs  = (b == 32'd0) ? 32'd1 : ((sdiv && b[31]) ? (32'd0 - b) : b);
  assign uq   = dvd / dvs;
  assign ur   = dvd % dvs;
  assign quo  = (sdiv && (a[31] ^ b[31])) ? (32'd0 - uq) : uq;
  assign rem  = (sdiv && a[31]) ? (32'd0 - ur) : ur;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_n_d  = hi_n_q;
    lo_n_d  = lo_n_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              {hi_n_d, lo_n_d} = (md_op == OP_MULT) ? prod_s : prod_u;
              cnt_d   = CW'(MULT_CYCLES);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              // A zero divisor commits the current HI/LO back unchanged.
              hi_n_d  = (b == 32'd0) ? hi_q : rem;
              lo_n_d  = (b == 32'd0) ? lo_q : quo;
              cnt_d   = CW'(DIV_CYCLES);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d    = hi_n_q;
          lo_d    = lo_n_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hi_n_q  <= 32'd0;
      lo_n_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_n_q  <= hi_n_d;
      lo_n_q  <= lo_n_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected {hi,lo} pushed at issue, popped at commit.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int errs   = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] opa,
                        input logic [31:0] opb, input int n, input logic [63:0] exp,
                        input bit inject);
    int cnt;
    logic [63:0] want;
    exp_q.push_back(exp);
    start = 1'b1; md_op = op; a = opa; b = opb;
    step();
    start = 1'b0; a = $urandom; b = $urandom;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      check_eq({tag, "_hold"}, {hi, lo}, {model_hi, model_lo});
      cnt++;
      // Illegal start mid-run with different operands must be ignored.
      if (inject && cnt == 2) begin
        start = 1'b1; md_op = 3'd3; a = 32'd100; b = 32'd7;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    check_eq({tag, "_busy_cycles"}, 64'(cnt), 64'(n));
    want = exp_q.pop_front();
    check_eq({tag, "_result"}, {hi, lo}, want);
    {model_hi, model_lo} = want;
  endtask

  task automatic mt_op(input string tag, input logic [2:0] op, input logic [31:0] val);
    logic [63:0] want;
    exp_q.push_back((op == 3'd4) ? {val, model_lo} : {model_hi, val});
    start = 1'b1; md_op = op; a = val; b = 32'd0;
    step();
    start = 1'b0;
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    want = exp_q.pop_front();
    check_eq({tag, "_result"}, {hi, lo}, want);
    {model_hi, model_lo} = want;
  endtask

  initial begin
    logic [31:0] ra, rb;
    longint      ps;
    int          cnt;

    reset = 1'b1; start = 1'b1; md_op = 3'd4; a = 32'hDEAD_BEEF; b = 32'd0;
    step();
    step();
    check_eq("reset_hold", {63'd0, busy} | {hi, lo}, 64'd0);
    reset = 1'b0; start = 1'b0;
    step();
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_hilo", {hi, lo}, 64'd0);

    run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
    run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 64'h0000_0002_FFFF_FFFA, 1'b0);
    mt_op("b2b_mthi", 3'd4, 32'h0000_1234);

    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_op("divu", 3'd3, 32'd7, 32'd2, 10, 64'h0000_0001_0000_0003, 1'b0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 64'h0000_0000_8000_0000, 1'b0);

    mt_op("mthi", 3'd4, 32'h0000_AAAA);
    mt_op("mtlo", 3'd5, 32'h0000_5555);
    run_op("divu_by0", 3'd3, 32'd99, 32'd0, 10, 64'h0000_AAAA_0000_5555, 1'b0);

    // Reserved opcodes leave state untouched and never raise busy.
    exp_q.push_back({model_hi, model_lo});
    start = 1'b1; md_op = 3'd7; a = 32'h1111_1111;
    step();
    start = 1'b0;
    check_eq("rsvd_busy", 64'(busy), 64'd0);
    check_eq("rsvd_hilo", {hi, lo}, exp_q.pop_front());

    run_op("mult_inject", 3'd0, 32'd6, 32'd7, 5, 64'd42, 1'b1);

    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom;
      ps = longint'($signed(ra)) * longint'($signed(rb));
      run_op("rnd_mult", 3'd0, ra, rb, 5, 64'(ps), 1'b0);
      run_op("rnd_multu", 3'd1, ra, rb, 5, {32'd0, ra} * {32'd0, rb}, 1'b0);
      rb = rb >> (i * 8);
      rb[0] = 1'b1;
      run_op("rnd_divu", 3'd3, ra, rb, 10, {ra % rb, ra / rb}, 1'b0);
    end

    // Reset in the third busy cycle discards the in-flight result.
    exp_q.push_back(64'h0000_0002_0000_0003);
    start = 1'b1; md_op = 3'd3; a = 32'd17; b = 32'd5;
    step();
    start = 1'b0;
    step();
    step();
    check_eq("rst_run_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    model_hi = 32'd0; model_lo = 32'd0;
    check_eq("rst_run_busy", 64'(busy), 64'd0);
    check_eq("rst_run_hilo", {hi, lo}, 64'd0);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (busy !== 1'b0 || {hi, lo} !== 64'd0) cnt++;
    end
    check_eq("rst_run_no_commit", 64'(cnt), 64'd0);

    run_op("post_rst_multu", 3'd1, 32'd3, 32'd4, 5, 64'd12, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit of the five-stage MIPS pipeline, sitting in the execute stage beside the ALU. It consumes the mult/multu/div/divu/mthi/mtlo instructions the decoder classifies as the md family, owns the HI/LO registers read by mfhi/mflo, and runs multi-cycle operations behind a `busy` flag. The stall unit uses `start | busy` to hold md-family and mfhi/mflo instructions in decode.

## Interface

Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (≥1).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  an md-family instruction is in execute this cycle.
- `md_op`  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6 and 7 are reserved.
- `a`  in  32  forwarded rs value.
- `b`  in  32  forwarded rt value.
- `busy`  out  1  multi-cycle operation in progress.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.

## Operation

- **State:** IDLE and RUN, a cycle counter, and result shadow registers `hi_n` and `lo_n`.
- **Reset:** on any edge with `reset=1`, go to IDLE.
  - `busy`, `hi`, `lo` and the counter all become 0.
  - Any in-flight result is discarded.
  - Reset takes priority over `start`.
- **IDLE with `start=1`:**
  - **mult/multu:**
    - Capture the 64-bit product of `a` and `b` into `hi_n:lo_n`.
    - mult is signed two's-complement; multu is unsigned.
    - Load the counter with `MULT_CYCLES`, then go to RUN.
  - **div/divu:**
    - `lo_n` = quotient, `hi_n` = remainder.
    - div is signed: the quotient truncates toward zero and the remainder takes the dividend's sign.
    - divu is unsigned.
    - div with `0x80000000 / 0xFFFFFFFF` gives `lo_n=0x80000000`, `hi_n=0`.
    - Load the counter with `DIV_CYCLES`, then go to RUN.
  - **div/divu with `b=0`:**
    - Still go to RUN for `DIV_CYCLES`.
    - At commit, `hi` and `lo` stay unchanged.
  - **mthi:** `hi <= a` at this edge. Stay in IDLE; `busy` stays 0.
  - **mtlo:** `lo <= a` at this edge. Stay in IDLE; `busy` stays 0.
  - **`md_op` 6 or 7:** no effect.
- **RUN:**
  - Decrement the counter each edge.
  - On the edge where the counter goes 1→0:
    - `hi <= hi_n` and `lo <= lo_n`.
    - Return to IDLE; `busy` falls at the same edge.
- **`start=1` during RUN:** ignored entirely; operands and `md_op` are not sampled. The stall unit guarantees this never happens legally.
- **`start=1` in the cycle after commit (IDLE again):** accepted normally (back-to-back operations).
- **Outputs:** `hi` and `lo` hold their old values throughout RUN. mfhi/mflo issued during RUN would read stale data, which is why the stall unit blocks them.

## Timing

- `busy` is registered. It is high exactly N cycles, where N = `MULT_CYCLES` or `DIV_CYCLES`, starting the cycle after the `start` edge.
- With `start` sampled at edge E0:
  - `busy` is 1 in cycles E0+1 … E0+N.
  - New `hi`/`lo` are visible from cycle E0+N+1, the first cycle with `busy=0`.
- mthi/mtlo: the new value is visible the cycle after the `start` edge. Latency 1, no busy.
- `busy`, `hi` and `lo` are driven directly from flops, with no combinational path from the inputs.
- **Reset asserted during RUN:** the next cycle shows `busy=0`, `hi=0`, `lo=0`. No late commit occurs after reset deasserts.
- The stall unit must treat `start | busy` as pending. `busy` alone misses the issue cycle.

## Test plan

- **Reset:** assert `reset` for 2 cycles with `start=1`, `md_op=4` → `busy=0`, `hi=0`, `lo=0` the cycle after release. No write occurs.
- **Signed mult:** `a=0xFFFFFFFE` (−2), `b=3`, `md_op=0`, default params → `busy` high exactly 5 cycles, then `hi=0xFFFFFFFF`, `lo=0xFFFFFFFA`. `hi`/`lo` unchanged while busy.
- **multu, same operands:**
  - `md_op=1` → `hi=0x00000002`, `lo=0xFFFFFFFA`.
  - Back-to-back: issue `md_op=4` with `a=0x1234` on the cycle `busy` falls → `hi=0x1234` one cycle later.
- **Divide:**
  - div `a=-7`, `b=2` → after 10 busy cycles, `lo=0xFFFFFFFD` (−3), `hi=0xFFFFFFFF` (−1).
  - divu `a=7`, `b=2` → `lo=3`, `hi=1`.
  - div `0x80000000 / 0xFFFFFFFF` → `lo=0x80000000`, `hi=0`.
- **Divide by zero:** preload `hi=0xAAAA` and `lo=0x5555` via mthi/mtlo, then divu `b=0` → `busy` high 10 cycles, then `hi=0xAAAA`, `lo=0x5555`.
- **Illegal and interrupted starts:**
  - `start` pulses during RUN with different operands → ignored; the original result commits on schedule.
  - `reset` at busy cycle 3 → `busy=0`, `hi=lo=0`, and no commit occurs later.
